// File: rtl/terminal_counter_if.sv
// Control/status bundle for terminal_counter; the counter itself sits on the slave modport.
// Optional wraps signal present only with TERMINAL_COUNTER_WRAPCNT_EN defined.
interface terminal_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             en;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tc;
`ifdef TERMINAL_COUNTER_WRAPCNT_EN
    logic [15:0]      wraps;

    modport master (output start, en, ack, input count, busy, done, tc, wraps);
    modport slave  (input start, en, ack, output count, busy, done, tc, wraps);
`else
    modport master (output start, en, ack, input count, busy, done, tc);
    modport slave  (input start, en, ack, output count, busy, done, tc);
`endif
endinterface

// File: rtl/terminal_counter.sv
// One-shot / auto-reload terminal counter running from START towards LIMIT.
// Define TERMINAL_COUNTER_WRAPCNT_EN to add the saturating tc-pulse counter 'wraps'.
module terminal_counter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned START  = 10,
    parameter int unsigned LIMIT  = 100,
    parameter bit          RELOAD = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    terminal_counter_if.slave  bus
);

    if ((longint'(START) >= (longint'(1) << WIDTH)) ||
        (longint'(LIMIT) >= (longint'(1) << WIDTH))) begin : g_range_err
        $error("terminal_counter: START or LIMIT does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] StartVal = WIDTH'(START);
    localparam logic [WIDTH-1:0] LimitVal = WIDTH'(LIMIT);
    localparam bit               CountUp  = (LIMIT >= START);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] count_step;

    assign count_step = CountUp ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

`ifdef TERMINAL_COUNTER_WRAPCNT_EN
    logic [15:0] wraps_q;
    assign bus.wraps = wraps_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= StartVal;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TERMINAL_COUNTER_WRAPCNT_EN
            wraps_q <= 16'd0;
`endif
        end else begin
            tc_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StRun;
                        count_q <= StartVal;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef TERMINAL_COUNTER_WRAPCNT_EN
                        wraps_q <= 16'd0;
`endif
                    end
                end
                StRun: begin
                    // start outranks a terminal on the same edge: restart without tc
                    if (bus.start) begin
                        count_q <= StartVal;
`ifdef TERMINAL_COUNTER_WRAPCNT_EN
                        wraps_q <= 16'd0;
`endif
                    end else if (bus.en) begin
                        if (count_q == LimitVal) begin
                            tc_q <= 1'b1;
`ifdef TERMINAL_COUNTER_WRAPCNT_EN
                            if (wraps_q != 16'hFFFF) wraps_q <= wraps_q + 16'd1;
`endif
                            if (RELOAD) begin
                                count_q <= StartVal;
                            end else begin
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            count_q <= count_step;
                        end
                    end
                end
                StDone: begin
                    if (bus.start) begin
                        state_q <= StRun;
                        count_q <= StartVal;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef TERMINAL_COUNTER_WRAPCNT_EN
                        wraps_q <= 16'd0;
`endif
                    end else if (bus.ack) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tc    = tc_q;

endmodule

// File: tb/tb_terminal_counter.sv
// Scoreboard bench for terminal_counter: three configurations (defaults, down auto-reload,
// START==LIMIT); expectations are queued per edge and checked by an independent monitor.
module tb_terminal_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0 = 1'b0;
    logic rst_n1 = 1'b0;
    logic rst_n2 = 1'b0;

    terminal_counter_if #(.WIDTH(8)) if0 ();
    terminal_counter_if #(.WIDTH(8)) if1 ();
    terminal_counter_if #(.WIDTH(8)) if2 ();

    terminal_counter #(.WIDTH(8), .START(10), .LIMIT(100), .RELOAD(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (if0)
    );
    terminal_counter #(.WIDTH(8), .START(5), .LIMIT(2), .RELOAD(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (if1)
    );
    terminal_counter #(.WIDTH(8), .START(7), .LIMIT(7), .RELOAD(1'b0)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n2),
        .bus   (if2)
    );

    typedef struct {
        int    d;
        string nm;
        int    c;
        bit    b;
        bit    dn;
        bit    t;
        bit    chk;
        int    w;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic drive(input int d, input bit r, input bit s, input bit e, input bit a);
        case (d)
            0: begin rst_n0 = r; if0.start = s; if0.en = e; if0.ack = a; end
            1: begin rst_n1 = r; if1.start = s; if1.en = e; if1.ack = a; end
            default: begin rst_n2 = r; if2.start = s; if2.en = e; if2.ack = a; end
        endcase
    endtask

    task automatic push(input int d, input string nm, input int c, input bit b, input bit dn,
                        input bit t, input bit chk = 1'b1, input int w = -1);
        exp_t x;
        x.d = d; x.nm = nm; x.c = c; x.b = b; x.dn = dn; x.t = t; x.chk = chk; x.w = w;
        sb.push_back(x);
    endtask

    task automatic check_val(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // One clock of stimulus on DUT d plus the state expected right after the next edge
    task automatic cyc(input int d, input bit r, input bit s, input bit e, input bit a,
                       input string nm, input int c, input bit b, input bit dn, input bit t,
                       input bit chk = 1'b1, input int w = -1);
        @(negedge clk);
        drive(d, r, s, e, a);
        push(d, nm, c, b, dn, t, chk, w);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL timeout: run did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor: pops every expectation queued for the edge just taken
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                exp_t x;
                int   ac;
                bit   ab, ad, at;
                int   aw;
                x = sb.pop_front();
                case (x.d)
                    0: begin ac = int'(if0.count); ab = if0.busy; ad = if0.done; at = if0.tc; end
                    1: begin ac = int'(if1.count); ab = if1.busy; ad = if1.done; at = if1.tc; end
                    default: begin
                        ac = int'(if2.count); ab = if2.busy; ad = if2.done; at = if2.tc;
                    end
                endcase
                aw = x.w;
`ifdef TERMINAL_COUNTER_WRAPCNT_EN
                case (x.d)
                    0: aw = int'(if0.wraps);
                    1: aw = int'(if1.wraps);
                    default: aw = int'(if2.wraps);
                endcase
                if (x.w < 0) aw = x.w;
`endif
                if (x.chk) begin
                    n_cmp++;
                    if (ac != x.c || ab != x.b || ad != x.dn || at != x.t || aw != x.w) begin
                        n_bad++;
                        $display("FAIL %s dut%0d: got count=%0d busy=%0b done=%0b tc=%0b wraps=%0d, expected count=%0d busy=%0b done=%0b tc=%0b wraps=%0d",
                                 x.nm, x.d, ac, ab, ad, at, aw, x.c, x.b, x.dn, x.t, x.w);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int pat[4];
        pat[0] = 4; pat[1] = 3; pat[2] = 2; pat[3] = 5;

        // Reset dominates start/en/ack on every instance
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b1, 1'b1, 1'b1);
            drive(1, 1'b0, 1'b1, 1'b1, 1'b1);
            drive(2, 1'b0, 1'b1, 1'b1, 1'b1);
            push(0, "reset", 10, 1'b0, 1'b0, 1'b0, 1'b1, 0);
            push(1, "reset", 5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
            push(2, "reset", 7, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        end
        @(negedge clk);
        check_val("reset_count0", int'(if0.count), 10);
        check_val("reset_busy0", int'(if0.busy), 0);
        check_val("reset_done0", int'(if0.done), 0);
        check_val("reset_tc0", int'(if0.tc), 0);
        check_val("reset_count1", int'(if1.count), 5);
        check_val("reset_count2", int'(if2.count), 7);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b1, 1'b0, 1'b0, 1'b0);

        // Full up-count with en held high
        cyc(0, 1, 1, 1, 0, "start_run", 10, 1, 0, 0, 1, 0);
        for (int k = 1; k <= 91; k++) begin
            cyc(0, 1, 0, 1, 0, (k == 91) ? "terminal_tc" : "count_up",
                (k <= 90) ? 10 + k : 100, k < 91, k == 91, k == 91, 1, (k == 91) ? 1 : 0);
        end
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1, 0, "done_hold", 100, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, "ack_idle", 100, 0, 0, 0);
        cyc(0, 1, 0, 1, 1, "idle_ignore_en_ack", 100, 0, 0, 0);

        // en toggling: count freezes on en=0 cycles
        cyc(0, 1, 1, 0, 0, "restart", 10, 1, 0, 0, 1, 0);
        n = 0;
        for (int i = 0; i < 182; i++) begin
            if (i % 2 == 0) n++;
            cyc(0, 1, 0, i % 2 == 0, 0, "en_toggle", (n <= 90) ? 10 + n : 100, n < 91,
                n >= 91, (i % 2 == 0) && n == 91);
        end
        cyc(0, 1, 0, 0, 1, "ack_idle2", 100, 0, 0, 0);

        // Reset mid-run aborts without tc; start honoured on the first released edge
        cyc(0, 1, 1, 0, 0, "start3", 10, 1, 0, 0);
        for (int k = 1; k <= 40; k++) cyc(0, 1, 0, 1, 0, "to_50", 10 + k, 1, 0, 0, k == 40);
        cyc(0, 0, 0, 1, 0, "reset_mid_run", 10, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 1, 0, "start_after_reset", 10, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, "count_after_reset", 11, 1, 0, 0);

        // start at count==LIMIT with en=1 restarts without tc
        for (int k = 1; k <= 89; k++) cyc(0, 1, 0, 1, 0, "to_limit", 11 + k, 1, 0, 0, k == 89);
        cyc(0, 1, 1, 1, 0, "start_at_limit", 10, 1, 0, 0, 1, 0);
        for (int k = 1; k <= 91; k++) begin
            cyc(0, 1, 0, 1, 0, "run_to_done", (k <= 90) ? 10 + k : 100, k < 91, k == 91,
                k == 91, k >= 90, (k == 91) ? 1 : 0);
        end
        cyc(0, 1, 1, 0, 1, "start_ack_together", 10, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 0, "after_start_wins", 11, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, "dut0_park", 11, 1, 0, 0, 0);

        // Down-counting auto-reload 5,4,3,2,5,...
        cyc(1, 1, 1, 1, 0, "reload_start", 5, 1, 0, 0, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc(1, 1, 0, 1, 0, "reload_seq", pat[(k - 1) % 4], 1, 0, (k - 1) % 4 == 3, 1,
                k / 4);
        end
        cyc(1, 1, 1, 1, 0, "reload_restart", 5, 1, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 1, "reload_hold", 5, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, "reload_resume", 4, 1, 0, 0);

        // START==LIMIT terminates on the first enabled edge
        cyc(2, 1, 1, 0, 0, "eq_start", 7, 1, 0, 0, 1, 0);
        cyc(2, 1, 0, 0, 0, "eq_hold_en0", 7, 1, 0, 0);
        cyc(2, 1, 0, 1, 0, "eq_tc", 7, 0, 1, 1, 1, 1);
        cyc(2, 1, 0, 1, 0, "eq_done", 7, 0, 1, 0);
        cyc(2, 1, 0, 0, 1, "eq_ack", 7, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
